// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control FSM: state encoding,
// opcode values, datapath select codes, trap codes and the opcode class record.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SEL_TARGET = 2'd1;
  localparam logic [1:0] PC_SEL_JALR   = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;
  localparam logic [1:0] WB_SEL_IMM = 2'd3;

  localparam logic [1:0] TRAP_ILLEGAL     = 2'd1;
  localparam logic [1:0] TRAP_MEM_TIMEOUT = 2'd2;

  typedef struct packed {
    logic lui;
    logic auipc;
    logic jal;
    logic jalr;
    logic branch;
    logic load;
    logic store;
    logic i_op;
    logic r_op;
  } opclass_t;

  // Wait counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_opclass_decode.sv
// Combinational opcode classifier: inst[6:0] to a one-hot class record plus
// an illegal flag for anything outside the supported RV32I base groups.
module multicycle_ctrl_opclass_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_t   opclass,
  output logic       illegal
);

  // One-hot classification; unknown opcodes raise illegal with no class bit.
  always_comb begin
    opclass = '0;
    illegal = 1'b0;
    case (opcode)
      OP_LUI:    opclass.lui    = 1'b1;
      OP_AUIPC:  opclass.auipc  = 1'b1;
      OP_JAL:    opclass.jal    = 1'b1;
      OP_JALR:   opclass.jalr   = 1'b1;
      OP_BRANCH: opclass.branch = 1'b1;
      OP_LOAD:   opclass.load   = 1'b1;
      OP_STORE:  opclass.store  = 1'b1;
      OP_IMM:    opclass.i_op   = 1'b1;
      OP_REG:    opclass.r_op   = 1'b1;
      default:   illegal        = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, and owns the single shared memory port.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT     = 15,
  parameter logic [1:0]  RESET_TRAP_CODE = 2'b00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        instret,
  output logic        trap,
  output logic [1:0]  trap_code
);

  localparam logic [7:0] TIMEOUT_LIM = MEM_TIMEOUT[7:0];

  state_t     state_r;
  state_t     state_next_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_next_s;
  logic [7:0] cnt_inc_s;
  logic       timeout_s;
  logic       instret_r;
  logic       trap_r;
  logic [1:0] trap_code_r;
  logic       trap_set_s;
  logic [1:0] trap_code_next_s;
  opclass_t   cls_s;
  logic       illegal_s;
  logic       op_a_pc_s;
  logic       op_b_imm_s;
  logic       unused_inst_s;

  multicycle_ctrl_opclass_decode u_opclass_decode (
    .opcode  (inst[6:0]),
    .opclass (cls_s),
    .illegal (illegal_s)
  );

  assign unused_inst_s = ^inst[31:7];

  // Operand selects per class; also driven in MEM and WB so the ALU result stays valid.
  assign op_a_pc_s  = cls_s.auipc | cls_s.jal | cls_s.branch;
  assign op_b_imm_s = cls_s.auipc | cls_s.jal | cls_s.branch | cls_s.jalr |
                      cls_s.load  | cls_s.store | cls_s.i_op;

  assign cnt_inc_s = sat_inc8(cnt_r);
  assign timeout_s = (cnt_inc_s >= TIMEOUT_LIM);

  // Next-state and datapath controls; outputs are suppressed while rst_n is low.
  always_comb begin
    state_next_s     = state_r;
    cnt_next_s       = 8'd0;
    trap_set_s       = 1'b0;
    trap_code_next_s = trap_code_r;
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    mem_addr_sel     = 1'b0;
    ir_we            = 1'b0;
    pc_we            = 1'b0;
    pc_sel           = PC_SEL_PLUS4;
    alu_a_sel        = 1'b0;
    alu_b_sel        = 1'b0;
    rf_we            = 1'b0;
    wb_sel           = WB_SEL_ALU;
    if (!rst_n) begin
      state_next_s = ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b0;
          if (mem_ready) begin
            ir_we        = 1'b1;
            state_next_s = ST_DECODE;
          end else if (timeout_s) begin
            state_next_s     = ST_TRAP;
            trap_set_s       = 1'b1;
            trap_code_next_s = TRAP_MEM_TIMEOUT;
          end else begin
            cnt_next_s = cnt_inc_s;
          end
        end
        ST_DECODE: begin
          if (illegal_s) begin
            state_next_s     = ST_TRAP;
            trap_set_s       = 1'b1;
            trap_code_next_s = TRAP_ILLEGAL;
          end else begin
            state_next_s = ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_a_sel = op_a_pc_s;
          alu_b_sel = op_b_imm_s;
          if (cls_s.load || cls_s.store) begin
            state_next_s = ST_MEM;
          end else begin
            state_next_s = ST_WB;
          end
        end
        ST_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = cls_s.store;
          alu_a_sel    = op_a_pc_s;
          alu_b_sel    = op_b_imm_s;
          if (mem_ready) begin
            state_next_s = ST_WB;
          end else if (timeout_s) begin
            state_next_s     = ST_TRAP;
            trap_set_s       = 1'b1;
            trap_code_next_s = TRAP_MEM_TIMEOUT;
          end else begin
            cnt_next_s = cnt_inc_s;
          end
        end
        ST_WB: begin
          pc_we     = 1'b1;
          alu_a_sel = op_a_pc_s;
          alu_b_sel = op_b_imm_s;
          rf_we     = ~(cls_s.store | cls_s.branch);
          if (cls_s.jal || (cls_s.branch && br_taken)) begin
            pc_sel = PC_SEL_TARGET;
          end else if (cls_s.jalr) begin
            pc_sel = PC_SEL_JALR;
          end else begin
            pc_sel = PC_SEL_PLUS4;
          end
          if (cls_s.load) begin
            wb_sel = WB_SEL_MEM;
          end else if (cls_s.jal || cls_s.jalr) begin
            wb_sel = WB_SEL_PC4;
          end else if (cls_s.lui) begin
            wb_sel = WB_SEL_IMM;
          end else begin
            wb_sel = WB_SEL_ALU;
          end
          state_next_s = ST_FETCH;
        end
        ST_TRAP: begin
          state_next_s = ST_TRAP;
        end
        default: begin
          state_next_s = ST_FETCH;
        end
      endcase
    end
  end

  // State, wait counter, retire pulse and sticky trap registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_FETCH;
      cnt_r       <= 8'd0;
      instret_r   <= 1'b0;
      trap_r      <= 1'b0;
      trap_code_r <= RESET_TRAP_CODE;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      instret_r <= (state_r == ST_WB);
      if (trap_set_s) begin
        trap_r      <= 1'b1;
        trap_code_r <= trap_code_next_s;
      end else begin
        trap_r      <= trap_r;
        trap_code_r <= trap_code_r;
      end
    end
  end

  assign instret   = instret_r;
  assign trap      = trap_r;
  assign trap_code = trap_code_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a directed instruction table,
// hand-written trap/reset sequences and random instructions against a model.
module tb_multicycle_ctrl;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = 32'd0;
  logic        br_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
  logic [1:0]  pc_sel;
  logic        alu_a_sel, alu_b_sel, rf_we;
  logic [1:0]  wb_sel;
  logic        instret, trap;
  logic [1:0]  trap_code;

  multicycle_ctrl #(.MEM_TIMEOUT(TMO), .RESET_TRAP_CODE(2'b00)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .rf_we(rf_we), .wb_sel(wb_sel), .instret(instret), .trap(trap), .trap_code(trap_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req, we, as, irw, pcw;
    logic [1:0] pcs;
    logic       a, b, rf;
    logic [1:0] wbs;
    logic       ir, tr;
    logic [1:0] tc;
  } ov_t;

  typedef enum int {C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_LD, C_ST, C_IOP, C_ROP, C_ILL} cls_e;

  typedef struct { logic rdy; ov_t exp; } cyc_t;

  typedef struct {
    string       name;
    logic [31:0] ins;
    int          fw, mw;
    logic        br;
    int          len;
    logic [1:0]  pcs;
    logic        rf;
    logic [1:0]  wbs;
  } vec_t;

  int   n_assert = 0;
  int   n_fail = 0;
  logic carry = 1'b0;
  cyc_t q[$];

  function automatic ov_t dut_vec();
    ov_t v;
    v = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
         rf_we, wb_sel, instret, trap, trap_code};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic cls_e cls_of(input logic [6:0] op);
    case (op)
      7'h37:   return C_LUI;
      7'h17:   return C_AUIPC;
      7'h6F:   return C_JAL;
      7'h67:   return C_JALR;
      7'h63:   return C_BR;
      7'h03:   return C_LD;
      7'h23:   return C_ST;
      7'h13:   return C_IOP;
      7'h33:   return C_ROP;
      default: return C_ILL;
    endcase
  endfunction

  function automatic void push(input logic rdy, input ov_t e);
    cyc_t c;
    c.rdy = rdy;
    c.exp = e;
    q.push_back(c);
  endfunction

  function automatic void push_trap(input int n, input logic [1:0] code);
    ov_t e;
    for (int k = 0; k < n; k++) begin
      e = '0;
      e.tr = 1'b1;
      e.tc = code;
      push(1'($urandom_range(0, 1)), e);
    end
  endfunction

  // Expected per-cycle outputs for one instruction, derived from the phase rules.
  function automatic void build(input logic [31:0] ins, input int fw, input int mw,
                                input logic br, input int ntrap);
    cls_e c;
    ov_t  e;
    logic ir, a, b, st, rdy;
    int   n;
    c = cls_of(ins[6:0]);
    ir = carry;
    carry = 1'b0;
    n = (fw >= TMO) ? TMO : fw + 1;
    for (int k = 0; k < n; k++) begin
      rdy = (fw < TMO) && (k == fw);
      e = '0;
      e.req = 1'b1;
      e.irw = rdy;
      e.ir = (k == 0) ? ir : 1'b0;
      push(rdy, e);
    end
    if (fw >= TMO) begin
      push_trap(ntrap, 2'd2);
      return;
    end
    push(1'($urandom_range(0, 1)), '0);
    if (c == C_ILL) begin
      push_trap(ntrap, 2'd1);
      return;
    end
    a = (c == C_AUIPC) || (c == C_JAL) || (c == C_BR);
    b = !((c == C_ROP) || (c == C_LUI));
    st = (c == C_ST);
    e = '0;
    e.a = a;
    e.b = b;
    push(1'($urandom_range(0, 1)), e);
    if ((c == C_LD) || st) begin
      n = (mw >= TMO) ? TMO : mw + 1;
      for (int k = 0; k < n; k++) begin
        rdy = (mw < TMO) && (k == mw);
        e = '0;
        e.req = 1'b1;
        e.we = st;
        e.as = 1'b1;
        e.a = a;
        e.b = b;
        push(rdy, e);
      end
      if (mw >= TMO) begin
        push_trap(ntrap, 2'd2);
        return;
      end
    end
    e = '0;
    e.pcw = 1'b1;
    e.a = a;
    e.b = b;
    e.pcs = ((c == C_JAL) || ((c == C_BR) && br)) ? 2'd1 : (c == C_JALR) ? 2'd2 : 2'd0;
    e.rf = !((c == C_ST) || (c == C_BR));
    e.wbs = (c == C_LD) ? 2'd1 : ((c == C_JAL) || (c == C_JALR)) ? 2'd2 :
            (c == C_LUI) ? 2'd3 : 2'd0;
    push(1'($urandom_range(0, 1)), e);
    carry = 1'b1;
  endfunction

  task automatic run(input logic [31:0] ins, input int fw, input int mw, input logic br,
                     input int ntrap, input int ncut, output int len, output ov_t wbv);
    ov_t got;
    int  n;
    q.delete();
    build(ins, fw, mw, br, ntrap);
    n = (ncut > 0 && ncut < q.size()) ? ncut : q.size();
    len = -1;
    wbv = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      inst = ins;
      br_taken = br;
      mem_ready = q[i].rdy;
      #1;
      got = dut_vec();
      chk($sformatf("cycle%0d_ins%h", i, ins), 32'(got), 32'(q[i].exp));
      if (got.pcw && len < 0) begin
        len = i + 1;
        wbv = got;
      end
    end
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    rst_n = 1'b0;
    carry = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      #1;
      chk($sformatf("reset%0d", k), 32'(dut_vec()), 32'd0);
    end
  endtask

  vec_t       tbl[10];
  logic [6:0] ops[9];
  int         len;
  ov_t        wbv;
  logic [31:0] r;

  initial begin
    tbl[0] = '{"addi",    32'h00500093, 0, 0, 1'b0,  4, 2'd0, 1'b1, 2'd0};
    tbl[1] = '{"lw",      32'h00002083, 3, 3, 1'b0, 11, 2'd0, 1'b1, 2'd1};
    tbl[2] = '{"beq_tk",  32'h00000463, 0, 0, 1'b1,  4, 2'd1, 1'b0, 2'd0};
    tbl[3] = '{"beq_nt",  32'h00000463, 1, 0, 1'b0,  5, 2'd0, 1'b0, 2'd0};
    tbl[4] = '{"jalr",    32'h000100E7, 0, 0, 1'b0,  4, 2'd2, 1'b1, 2'd2};
    tbl[5] = '{"jal",     32'h010000EF, 0, 0, 1'b1,  4, 2'd1, 1'b1, 2'd2};
    tbl[6] = '{"lui",     32'h123450B7, 0, 0, 1'b0,  4, 2'd0, 1'b1, 2'd3};
    tbl[7] = '{"sw",      32'h00112023, 1, 2, 1'b0,  8, 2'd0, 1'b0, 2'd0};
    tbl[8] = '{"auipc",   32'h00000097, 2, 0, 1'b0,  6, 2'd0, 1'b1, 2'd0};
    tbl[9] = '{"add",     32'h002081B3, 0, 0, 1'b1,  4, 2'd0, 1'b1, 2'd0};
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

    do_reset(3);

    foreach (tbl[i]) begin
      run(tbl[i].ins, tbl[i].fw, tbl[i].mw, tbl[i].br, 0, 0, len, wbv);
      chk({tbl[i].name, "_len"}, 32'(len), 32'(tbl[i].len));
      chk({tbl[i].name, "_wb"}, {27'd0, wbv.pcs, wbv.rf, wbv.wbs},
          {27'd0, tbl[i].pcs, tbl[i].rf, tbl[i].wbs});
    end

    // Illegal opcode: trap after decode, absorbing, no retire.
    run(32'h0000007F, 0, 0, 1'b0, 5, 0, len, wbv);
    chk("illegal_no_wb", 32'(len), 32'hFFFFFFFF);
    do_reset(2);

    // Fetch timeout: exactly TMO request cycles, then trap code 2.
    run(32'h00500093, TMO, 0, 1'b0, 3, 0, len, wbv);
    do_reset(2);

    // Data-phase timeout on a load.
    run(32'h00002083, 0, TMO, 1'b0, 3, 0, len, wbv);
    do_reset(2);

    // Reset in the middle of a store's memory phase, then normal resume.
    run(32'h00112023, 0, 8, 1'b0, 0, 5, len, wbv);
    do_reset(2);
    run(32'h00500093, 0, 0, 1'b0, 0, 0, len, wbv);
    chk("resume_len", 32'(len), 32'd4);

    for (int i = 0; i < 40; i++) begin
      r = $urandom();
      run({r[31:7], ops[$urandom_range(0, 8)]}, $urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), 0, 0, len, wbv);
    end
    // Trailing cycle observes the retire pulse of the last random instruction.
    run(32'h00500093, 0, 0, 1'b0, 0, 1, len, wbv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Owns the single shared memory port and arbitrates it between instruction fetch (address = PC) and data access (address = ALU result).
- Drives all datapath select/enable lines; the immediate decoder and ALU operate on the instruction register it loads.

Parameters:
- MEM_TIMEOUT, 15, max cycles to wait for mem_ready in any wait state before trapping (1..255).
- RESET_TRAP_CODE, 2'b00, trap_code value while no trap has occurred.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- inst  in  32  current instruction register contents
- br_taken  in  1  branch comparison result from ALU, valid in EXEC/WB
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = store, 0 = read
- mem_addr_sel  out  1  0 = PC (fetch), 1 = ALU result (data)
- ir_we  out  1  load instruction register from memory read data
- pc_we  out  1  update PC
- pc_sel  out  2  0 = PC+4, 1 = ALU target (branch/jal), 2 = ALU target with bit0 cleared (jalr)
- alu_a_sel  out  1  0 = rs1, 1 = PC
- alu_b_sel  out  1  0 = rs2, 1 = immediate
- rf_we  out  1  register-file write enable
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4, 3 = immediate
- instret  out  1  one-cycle pulse per retired instruction (registered)
- trap  out  1  sticky halt indicator (registered)
- trap_code  out  2  1 = illegal opcode, 2 = memory timeout

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset (rst_n=0 at a clk edge): state=FETCH; timeout counter=0; instret=0; trap=0; trap_code=RESET_TRAP_CODE. Reset mid-operation drops mem_req on the next edge; no PC/RF write occurs.
- Combinational outputs are 0 unless stated below.
- FETCH:
  - mem_req=1, mem_addr_sel=0.
  - On mem_ready: ir_we=1, go to DECODE. Zero-wait ready (same cycle as req) is accepted.
  - Otherwise increment the counter. If the counter reaches MEM_TIMEOUT: go to TRAP, trap_code=2.
- DECODE (1 cycle): classify inst[6:0] against lui, auipc, jal, jalr, branch, load, store, I_op, R_op.
  - Any other opcode: TRAP, trap_code=1.
  - Otherwise go to EXEC.
- EXEC (1 cycle): set ALU operands.
  - auipc/jal/branch: alu_a_sel=1, alu_b_sel=1 (PC+imm).
  - jalr/load/store/I_op: alu_a_sel=0, alu_b_sel=1.
  - R_op: alu_a_sel=0, alu_b_sel=0.
  - load/store go to MEM; all others go to WB.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=1 for store.
  - Same ready/timeout rules as FETCH.
  - On mem_ready: go to WB.
- WB (1 cycle):
  - pc_we=1, with pc_sel=1 for jal and for branch when br_taken=1; pc_sel=2 for jalr; otherwise 0.
  - rf_we=1 for all classes except store and branch.
  - wb_sel: load=1, jal/jalr=2, lui=3, others=0.
  - instret pulses on the next cycle. Go to FETCH.
- Timeout counter clears on every entry to FETCH or MEM. Width is 8 bits and it saturates, never wraps.
- TRAP: absorbing until reset; all enables 0; trap=1.
- Hold operand selects steady in WB for the same opcode, so ALU results remain valid at the write.
- Latency: minimum 4 cycles per instruction for non-memory classes, 5 for load/store; add memory wait cycles.
- No request is ever issued while in DECODE, EXEC, WB or TRAP.

Decomposition:
- Shared header (macro.vh) holds: opcode macros (existing), state encodings, pc_sel/wb_sel codes, trap codes.
- One natural sub-module: opclass_decode, combinational inst[6:0] to {class one-hot, illegal}. Reusable by the immediate decoder's users and a future pipeline.

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready zero-wait -> states F,D,E,W; WB: rf_we=1, wb_sel=0, alu_b_sel=1, pc_sel=0; instret pulse at cycle 5.
- LW with mem_ready delayed 3 cycles in both FETCH and MEM -> 11 cycles total; ir_we single pulse; WB wb_sel=1.
- BEQ taken (br_taken=1) vs not taken -> WB pc_sel=1 vs 0, rf_we=0 both cases; JALR -> pc_sel=2, wb_sel=2.
- Opcode 0x7F in IR -> TRAP after DECODE, trap=1, trap_code=1, all enables 0 thereafter, no instret.
- mem_ready held 0 in FETCH -> exactly MEM_TIMEOUT=15 cycles of mem_req, then trap_code=2.
- rst_n low during MEM of an SW -> next edge state FETCH, mem_req/mem_we 0, no pc_we/rf_we; normal fetch resumes after release.
